// File: rtl/cdc_pulse_req_pkg.sv
// Shared types for the multi-channel pulse-to-handshake launcher.
// One-hot channel state encoding and the pending-counter ceiling helper.
package cdc_pulse_req_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b001,
    ST_REQ     = 3'b010,
    ST_RELEASE = 3'b100
  } chanState_e;

  localparam int DEF_CW = 4;

  function automatic int maxCount(input int cw);
    return (1 << cw) - 1;
  endfunction

endpackage

// File: rtl/cdc_pulse_req_chan.sv
// One channel: ack synchroniser, handshake FSM, saturating event queue, sticky errors.
// Optional ack watchdog is built when CDC_PULSE_REQ_TIMEOUT_EN is defined.
module cdc_pulse_req_chan
  import cdc_pulse_req_pkg::*;
#(
  parameter int CW          = DEF_CW,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic          clk,
  input  logic          aresetn,
  input  logic          pulse_in,
  input  logic          ack_in,
  input  logic          err_clr,
  output logic          req_out,
  output logic          busy,
  output logic [CW-1:0] pending,
  output logic          overflow,
  output logic          timeout
);

  localparam logic [CW-1:0] MAX_CNT = CW'(maxCount(CW));

  logic [SYNC_STAGES-1:0] r_ackSync;
  chanState_e             r_state;
  chanState_e             w_nextState;
  logic [CW-1:0]          r_count;
  logic                   r_overflow;
  logic                   w_ackS;
  logic                   w_haveWork;
  logic                   w_dispatch;
  logic                   w_ovfSet;

  assign w_ackS     = r_ackSync[SYNC_STAGES-1];
  assign w_haveWork = (r_count != '0) || pulse_in;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) r_ackSync <= '0;
    else          r_ackSync <= {r_ackSync[SYNC_STAGES-2:0], ack_in};
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) r_state <= ST_IDLE;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:    if (w_haveWork) w_nextState = ST_REQ;
      ST_REQ:     if (w_ackS) w_nextState = ST_RELEASE;
      ST_RELEASE: if (!w_ackS) w_nextState = w_haveWork ? ST_REQ : ST_IDLE;
      default:    w_nextState = ST_IDLE;
    endcase
  end

  // An event is consumed on every entry into REQ; a pulse that feeds it directly never lands in the queue.
  assign w_dispatch = (r_state != ST_REQ) && (w_nextState == ST_REQ);
  assign w_ovfSet   = pulse_in && !w_dispatch && (r_count == MAX_CNT);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_count <= '0;
    end else if (w_dispatch) begin
      if ((r_count != '0) && !pulse_in) r_count <= r_count - 1'b1;
    end else if (pulse_in && (r_count != MAX_CNT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) r_overflow <= 1'b0;
    else          r_overflow <= w_ovfSet | (r_overflow & ~err_clr);
  end

  assign req_out  = (r_state == ST_REQ);
  assign busy     = (r_state != ST_IDLE) || (r_count != '0);
  assign pending  = r_count;
  assign overflow = r_overflow;

`ifdef CDC_PULSE_REQ_TIMEOUT_EN
  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT);

  logic [TW-1:0] r_wdCnt;
  logic          r_timeout;
  logic          w_wdActive;
  logic          w_stateChg;
  logic          w_toSet;

  assign w_wdActive = (r_state != ST_IDLE);
  assign w_stateChg = (r_state != w_nextState);
  // Flag on the edge that would bring the count to TIMEOUT, so it is visible TIMEOUT cycles after entry.
  assign w_toSet    = w_wdActive && !w_stateChg && (r_wdCnt == TO_LIMIT - 1'b1);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)                     r_wdCnt <= '0;
    else if (!w_wdActive || w_stateChg) r_wdCnt <= '0;
    else if (r_wdCnt != TO_LIMIT)       r_wdCnt <= r_wdCnt + 1'b1;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) r_timeout <= 1'b0;
    else          r_timeout <= w_toSet | (r_timeout & ~err_clr);
  end

  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: rtl/cdc_pulse_req.sv
// N independent pulse-to-four-phase-handshake launchers sharing clock, reset and err_clr.
// Build with CDC_PULSE_REQ_TIMEOUT_EN defined to enable the per-channel ack watchdog.
module cdc_pulse_req
  import cdc_pulse_req_pkg::*;
#(
  parameter int N           = 4,
  parameter int CW          = DEF_CW,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic            clk,
  input  logic            aresetn,
  input  logic [N-1:0]    pulse_in,
  output logic [N-1:0]    req_out,
  input  logic [N-1:0]    ack_in,
  output logic [N-1:0]    busy,
  output logic [N*CW-1:0] pending,
  output logic [N-1:0]    overflow,
  output logic [N-1:0]    timeout,
  input  logic            err_clr
);

  for (genvar gi = 0; gi < N; gi++) begin : gChan
    cdc_pulse_req_chan #(
      .CW          (CW),
      .SYNC_STAGES (SYNC_STAGES),
      .TIMEOUT     (TIMEOUT)
    ) uChan (
      .clk      (clk),
      .aresetn  (aresetn),
      .pulse_in (pulse_in[gi]),
      .ack_in   (ack_in[gi]),
      .err_clr  (err_clr),
      .req_out  (req_out[gi]),
      .busy     (busy[gi]),
      .pending  (pending[gi*CW +: CW]),
      .overflow (overflow[gi]),
      .timeout  (timeout[gi])
    );
  end

endmodule

// File: tb/tb_cdc_pulse_req.sv
// Self-checking bench for cdc_pulse_req: scoreboard of expected req rising edges plus inline checks.
module tb_cdc_pulse_req;

  localparam int N    = 4;
  localparam int CW   = 4;
  localparam int SS   = 2;
  localparam int TO   = 16;
  localparam int MAXC = 15;
`ifdef CDC_PULSE_REQ_TIMEOUT_EN
  localparam logic TO_ON = 1'b1;
`else
  localparam logic TO_ON = 1'b0;
`endif

  logic            clk      = 1'b0;
  logic            aresetn  = 1'b0;
  logic            err_clr  = 1'b0;
  logic [N-1:0]    pulse_in = '0;
  logic [N-1:0]    loopEn   = '0;
  logic [N-1:0]    ackForce = '0;
  logic [N-1:0]    ack_in;
  logic [N-1:0]    req_out;
  logic [N-1:0]    busy;
  logic [N-1:0]    overflow;
  logic [N-1:0]    timeout;
  logic [N*CW-1:0] pending;

  int testCount = 0;
  int failCount = 0;
  int cyc = 0;
  int expRise[N][$];
  int lastRise[N];
  logic [N-1:0] prevReq = '0;

  cdc_pulse_req #(.N(N), .CW(CW), .SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .aresetn  (aresetn),
    .pulse_in (pulse_in),
    .req_out  (req_out),
    .ack_in   (ack_in),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow),
    .timeout  (timeout),
    .err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  assign ack_in = (loopEn & req_out) | (~loopEn & ackForce);

  always @(posedge clk) cyc <= cyc + 1;

  // Every req rising edge must match the next scheduled edge for that channel.
  always @(posedge clk) begin : monitor
    int e;
    #1;
    for (int i = 0; i < N; i++) begin
      if (req_out[i] && !prevReq[i]) begin
        testCount++;
        if (expRise[i].size() == 0) begin
          failCount++;
          $display("[TB] FAIL reqRise ch%0d: rise at edge %0d, none expected", i, cyc);
        end else begin
          e = expRise[i].pop_front();
          if (cyc !== e) begin
            failCount++;
            $display("[TB] FAIL reqRise ch%0d: rose at edge %0d, expected edge %0d", i, cyc, e);
          end
        end
      end
    end
    prevReq = req_out;
  end

  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: simulation did not finish, tests=%0d failed=%0d", testCount, failCount);
    $fatal(1, "[TB] global timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic stepUntil(input int target);
    while (cyc < target) step();
  endtask

  // Holds pulse for exactly one sampling edge; tracked pulses schedule the rise a loopback channel will produce.
  task automatic drivePulse(input int ch, input bit track, output int s);
    int e;
    pulse_in[ch] = 1'b1;
    s = cyc + 1;
    if (track) begin
      e = (lastRise[ch] + 6 > s) ? lastRise[ch] + 6 : s;
      expRise[ch].push_back(e);
      lastRise[ch] = e;
    end
    step();
    pulse_in[ch] = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    testCount++; if (req_out !== '0)  begin failCount++; $display("[TB] FAIL reset_req: got %b want 0", req_out); end
    testCount++; if (busy !== '0)     begin failCount++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    testCount++; if (pending !== '0)  begin failCount++; $display("[TB] FAIL reset_pending: got %h want 0", pending); end
    testCount++; if (overflow !== '0) begin failCount++; $display("[TB] FAIL reset_overflow: got %b want 0", overflow); end
    testCount++; if (timeout !== '0)  begin failCount++; $display("[TB] FAIL reset_timeout: got %b want 0", timeout); end
    aresetn = 1'b1;
    step();
  endtask

  task automatic test_single();
    int s;
    loopEn[0] = 1'b1;
    drivePulse(0, 1'b1, s);
    for (int k = 0; k <= 6; k++) begin
      stepUntil(s + k);
      testCount++;
      if (req_out[0] !== (k < 3)) begin
        failCount++; $display("[TB] FAIL single_req k=%0d: got %b want %b", k, req_out[0], (k < 3));
      end
      testCount++;
      if (busy[0] !== (k < 6)) begin
        failCount++; $display("[TB] FAIL single_busy k=%0d: got %b want %b", k, busy[0], (k < 6));
      end
      testCount++;
      if (pending[0 +: CW] !== '0) begin
        failCount++; $display("[TB] FAIL single_pending k=%0d: got %0d want 0", k, pending[0 +: CW]);
      end
    end
    testCount++;
    if (overflow[0] !== 1'b0 || timeout[0] !== 1'b0) begin
      failCount++; $display("[TB] FAIL single_errors: ovf=%b to=%b want 0,0", overflow[0], timeout[0]);
    end
  endtask

  task automatic test_back_to_back();
    int s[3];
    int expPend[3] = '{0, 1, 2};
    loopEn[1] = 1'b1;
    for (int p = 0; p < 3; p++) begin
      drivePulse(1, 1'b1, s[p]);
      testCount++;
      if (pending[CW +: CW] !== CW'(expPend[p])) begin
        failCount++; $display("[TB] FAIL b2b_fill p=%0d: got %0d want %0d", p, pending[CW +: CW], expPend[p]);
      end
    end
    stepUntil(s[0] + 6);
    testCount++;
    if (pending[CW +: CW] !== CW'(1)) begin
      failCount++; $display("[TB] FAIL b2b_drain1: got %0d want 1", pending[CW +: CW]);
    end
    stepUntil(s[0] + 12);
    testCount++;
    if (pending[CW +: CW] !== CW'(0)) begin
      failCount++; $display("[TB] FAIL b2b_drain2: got %0d want 0", pending[CW +: CW]);
    end
    for (int k = 0; k < 40 && busy[1]; k++) step();
    testCount++;
    if (busy[1] !== 1'b0 || cyc !== s[0] + 18) begin
      failCount++; $display("[TB] FAIL b2b_idle: busy=%b at edge %0d, want 0 at edge %0d", busy[1], cyc, s[0] + 18);
    end
    testCount++;
    if (expRise[1].size() !== 0) begin
      failCount++; $display("[TB] FAIL b2b_count: %0d req edges missing, want 0", expRise[1].size());
    end
  endtask

  task automatic test_coincident();
    int s1, s2, s3;
    drivePulse(0, 1'b1, s1);
    drivePulse(0, 1'b1, s2);
    testCount++;
    if (pending[0 +: CW] !== CW'(1)) begin
      failCount++; $display("[TB] FAIL coinc_pre: got %0d want 1", pending[0 +: CW]);
    end
    stepUntil(s1 + 5);
    drivePulse(0, 1'b1, s3);
    testCount++;
    if (pending[0 +: CW] !== CW'(1)) begin
      failCount++; $display("[TB] FAIL coinc_hold: got %0d want 1 at edge %0d", pending[0 +: CW], s3);
    end
    stepUntil(s1 + 12);
    testCount++;
    if (pending[0 +: CW] !== CW'(0)) begin
      failCount++; $display("[TB] FAIL coinc_drain: got %0d want 0", pending[0 +: CW]);
    end
    for (int k = 0; k < 40 && busy[0]; k++) step();
    testCount++;
    if (busy[0] !== 1'b0 || expRise[0].size() !== 0) begin
      failCount++; $display("[TB] FAIL coinc_total: busy=%b missing edges=%0d want 0,0", busy[0], expRise[0].size());
    end
  endtask

  task automatic test_saturation();
    int s;
    loopEn[2]   = 1'b0;
    ackForce[2] = 1'b0;
    drivePulse(2, 1'b1, s);
    for (int p = 1; p <= MAXC; p++) drivePulse(2, 1'b0, s);
    testCount++;
    if (pending[2*CW +: CW] !== CW'(MAXC) || overflow[2] !== 1'b0) begin
      failCount++; $display("[TB] FAIL sat_full: pend=%0d ovf=%b want %0d,0", pending[2*CW +: CW], overflow[2], MAXC);
    end
    drivePulse(2, 1'b0, s);
    testCount++;
    if (pending[2*CW +: CW] !== CW'(MAXC) || overflow[2] !== 1'b1) begin
      failCount++; $display("[TB] FAIL sat_ovf: pend=%0d ovf=%b want %0d,1", pending[2*CW +: CW], overflow[2], MAXC);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    testCount++;
    if (overflow[2] !== 1'b0) begin
      failCount++; $display("[TB] FAIL sat_clr: got %b want 0", overflow[2]);
    end
    err_clr = 1'b1;
    drivePulse(2, 1'b0, s);
    err_clr = 1'b0;
    testCount++;
    if (overflow[2] !== 1'b1) begin
      failCount++; $display("[TB] FAIL sat_clr_vs_set: got %b want 1", overflow[2]);
    end
    testCount++;
    if (req_out[2] !== 1'b1 || pending[2*CW +: CW] !== CW'(MAXC)) begin
      failCount++; $display("[TB] FAIL sat_hold: req=%b pend=%0d want 1,%0d", req_out[2], pending[2*CW +: CW], MAXC);
    end
  endtask

  task automatic test_reset_mid();
    int s;
    loopEn[3]   = 1'b0;
    ackForce[3] = 1'b0;
    drivePulse(3, 1'b1, s);
    for (int p = 0; p < 5; p++) drivePulse(3, 1'b0, s);
    testCount++;
    if (pending[3*CW +: CW] !== CW'(5) || req_out[3] !== 1'b1) begin
      failCount++; $display("[TB] FAIL rstmid_pre: pend=%0d req=%b want 5,1", pending[3*CW +: CW], req_out[3]);
    end
    #2;
    aresetn = 1'b0;
    #1;
    testCount++;
    if (req_out !== '0 || pending !== '0 || busy !== '0) begin
      failCount++; $display("[TB] FAIL rstmid_async: req=%b pend=%h busy=%b want 0", req_out, pending, busy);
    end
    step();
    step();
    aresetn = 1'b1;
    for (int i = 0; i < N; i++) lastRise[i] = -100;
    repeat (3) step();
    testCount++;
    if (req_out !== '0 || busy !== '0 || overflow !== '0) begin
      failCount++; $display("[TB] FAIL rstmid_idle: req=%b busy=%b ovf=%b want 0", req_out, busy, overflow);
    end
  endtask

  task automatic test_timeout();
    int s;
    loopEn[3]   = 1'b0;
    ackForce[3] = 1'b0;
    drivePulse(3, 1'b1, s);
    stepUntil(s + 15);
    testCount++;
    if (timeout[3] !== 1'b0) begin
      failCount++; $display("[TB] FAIL to_early: got %b want 0", timeout[3]);
    end
    step();
    testCount++;
    if (timeout[3] !== TO_ON) begin
      failCount++; $display("[TB] FAIL to_set: got %b want %b", timeout[3], TO_ON);
    end
    testCount++;
    if (req_out[3] !== 1'b1) begin
      failCount++; $display("[TB] FAIL to_req_held: got %b want 1", req_out[3]);
    end
    ackForce[3] = 1'b1;
    stepUntil(s + 18);
    testCount++;
    if (req_out[3] !== 1'b1) begin
      failCount++; $display("[TB] FAIL to_late_ack_wait: got %b want 1", req_out[3]);
    end
    step();
    testCount++;
    if (req_out[3] !== 1'b0) begin
      failCount++; $display("[TB] FAIL to_late_ack_drop: got %b want 0", req_out[3]);
    end
    ackForce[3] = 1'b0;
    for (int k = 0; k < 20 && busy[3]; k++) step();
    testCount++;
    if (busy[3] !== 1'b0 || timeout[3] !== TO_ON) begin
      failCount++; $display("[TB] FAIL to_complete: busy=%b to=%b want 0,%b", busy[3], timeout[3], TO_ON);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    testCount++;
    if (timeout[3] !== 1'b0) begin
      failCount++; $display("[TB] FAIL to_clr: got %b want 0", timeout[3]);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) lastRise[i] = -100;
    test_reset();
    test_single();
    test_back_to_back();
    test_coincident();
    test_saturation();
    test_reset_mid();
    test_timeout();
    repeat (2) step();
    for (int i = 0; i < N; i++) begin
      testCount++;
      if (expRise[i].size() !== 0) begin
        failCount++; $display("[TB] FAIL leftover ch%0d: %0d req edges never seen, want 0", i, expRise[i].size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
